// File: rtl/scan_config_loader_pkg.sv
// Shared definitions for the configuration scan-chain loader: FSM state
// encodings, default geometry and a small sizing helper.
package scan_config_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int DEFAULT_WORD_WIDTH   = 8;
    localparam int DEFAULT_CHAIN_LENGTH = 64;

    // Smaller of two integers; sizes the final (possibly partial) word.
    function automatic int min_int(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/scan_config_loader_piso_reg.sv
// Parallel-in / serial-out shift buffer for outgoing configuration bits,
// plus an indexed serial-in capture register for the bits leaving the chain.
module scan_config_loader_piso_reg #(
    parameter int WIDTH     = 8,
    parameter int IDX_WIDTH = $clog2(WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 shift,
    input  logic [WIDTH-1:0]     par_in,
    input  logic                 ser_in,
    input  logic [IDX_WIDTH-1:0] cap_idx,
    output logic                 ser_out,
    output logic [WIDTH-1:0]     cap_word
);

    logic [WIDTH-1:0] shift_buf_reg;
    logic [WIDTH-1:0] cap_reg;
    logic [WIDTH-1:0] cap_hit;

    // One-hot select of the capture bit addressed by cap_idx during a shift.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cap_hit
            assign cap_hit[gi] = shift && (cap_idx == IDX_WIDTH'(gi));
        end
    endgenerate

    // Outgoing buffer: load a whole word, then shift right with zero fill.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_buf_reg <= '0;
        end else if (load) begin
            shift_buf_reg <= par_in;
        end else if (shift) begin
            shift_buf_reg <= {1'b0, shift_buf_reg[WIDTH-1:1]};
        end
    end

    // Capture register: cleared on each new word so unfilled upper bits read 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_reg <= '0;
        end else if (load) begin
            cap_reg <= '0;
        end else begin
            cap_reg <= (cap_reg & ~cap_hit) | (cap_hit & {WIDTH{ser_in}});
        end
    end

    assign ser_out  = shift_buf_reg[0];
    assign cap_word = cap_reg;

endmodule

// File: rtl/scan_config_loader.sv
// Configuration scan-chain front end: accepts words over valid/ready,
// shifts exactly CHAIN_LENGTH bits LSB-first into the chain and assembles
// the bits falling out of the chain end into readback words.
module scan_config_loader
    import scan_config_loader_pkg::*;
#(
    parameter int WORD_WIDTH   = DEFAULT_WORD_WIDTH,
    parameter int CHAIN_LENGTH = DEFAULT_CHAIN_LENGTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WORD_WIDTH-1:0] cfg_word,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    output logic                  chain_scan_in,
    output logic                  chain_scan_en,
    input  logic                  chain_scan_out,
    output logic [WORD_WIDTH-1:0] readback_word,
    output logic                  readback_valid,
    output logic                  busy,
    output logic                  done
);

    localparam int CNT_WIDTH = $clog2(CHAIN_LENGTH + 1);
    localparam int WB_WIDTH  = $clog2(WORD_WIDTH + 1);

    state_t               state_reg, state_next;
    logic [CNT_WIDTH-1:0] count_reg, count_next;
    logic [WB_WIDTH-1:0]  word_bits_reg, word_bits_next;
    logic [WB_WIDTH-1:0]  bit_idx_reg, bit_idx_next;
    logic                 readback_valid_reg, readback_valid_next;
    logic [WB_WIDTH-1:0]  remaining_bits;
    logic                 accept;
    logic                 shift_en;
    logic                 last_bit;
    logic                 piso_lsb;

    assign accept   = (state_reg == ST_LOAD) && cfg_valid;
    assign shift_en = (state_reg == ST_SHIFT);
    assign last_bit = (bit_idx_reg == word_bits_reg - WB_WIDTH'(1));

    // Bits the next word may contribute: a full word, or what is left of the chain.
    always_comb begin
        remaining_bits = WB_WIDTH'(min_int(WORD_WIDTH, CHAIN_LENGTH - int'(count_reg)));
    end

    // State and counter registers; reset stops any load in progress at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg          <= ST_IDLE;
            count_reg          <= '0;
            word_bits_reg      <= '0;
            bit_idx_reg        <= '0;
            readback_valid_reg <= 1'b0;
        end else begin
            state_reg          <= state_next;
            count_reg          <= count_next;
            word_bits_reg      <= word_bits_next;
            bit_idx_reg        <= bit_idx_next;
            readback_valid_reg <= readback_valid_next;
        end
    end

    // Next-state logic: one LOAD handshake per word, then word_bits shifts.
    always_comb begin
        state_next          = state_reg;
        count_next          = count_reg;
        word_bits_next      = word_bits_reg;
        bit_idx_next        = bit_idx_reg;
        readback_valid_next = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_LOAD;
                    count_next = '0;
                end
            end
            ST_LOAD: begin
                if (cfg_valid) begin
                    word_bits_next = remaining_bits;
                    bit_idx_next   = '0;
                    state_next     = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                count_next   = count_reg + CNT_WIDTH'(1);
                bit_idx_next = bit_idx_reg + WB_WIDTH'(1);
                if (last_bit) begin
                    readback_valid_next = 1'b1;
                    state_next = (count_reg == CNT_WIDTH'(CHAIN_LENGTH - 1)) ? ST_DONE : ST_LOAD;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    scan_config_loader_piso_reg #(
        .WIDTH     (WORD_WIDTH),
        .IDX_WIDTH (WB_WIDTH)
    ) u_piso (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .shift    (shift_en),
        .par_in   (cfg_word),
        .ser_in   (chain_scan_out),
        .cap_idx  (bit_idx_reg),
        .ser_out  (piso_lsb),
        .cap_word (readback_word)
    );

    assign cfg_ready      = (state_reg == ST_LOAD);
    assign chain_scan_en  = shift_en;
    assign chain_scan_in  = shift_en & piso_lsb;
    assign busy           = (state_reg == ST_LOAD) || (state_reg == ST_SHIFT);
    assign done           = (state_reg == ST_DONE);
    assign readback_valid = readback_valid_reg;

endmodule
